// File: rtl/alarm_scheduler.sv
// One-shot alarm slots matched against a free-running time count, events queued lowest-slot-first.
// Optional snooze re-arm on acknowledge is built when ALARM_SNOOZE_EN is defined.
module alarm_scheduler #(
    parameter int          NUM_SLOTS    = 4,
    parameter int          SLOT_W       = 2,
    parameter logic [15:0] SNOOZE_DELAY = 16'd300
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          cur_time,
    input  logic                 wr_en,
    input  logic [SLOT_W-1:0]    wr_slot,
    input  logic [15:0]          wr_time,
    input  logic                 wr_arm,
    input  logic                 alarm_ack,
`ifdef ALARM_SNOOZE_EN
    input  logic                 snooze,
`endif
    output logic                 alarm_valid,
    output logic [SLOT_W-1:0]    alarm_slot,
    output logic [NUM_SLOTS-1:0] armed,
    output logic [NUM_SLOTS-1:0] pending,
    output logic                 overrun
);

    logic [15:0]          prev_time;
    logic [15:0]          slot_time [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] wr_hit, snz_hit, match, hit_q, pend_nxt;
    logic [SLOT_W-1:0]    sel;
    logic                 tick, load, ov_set;

    assign tick = (cur_time != prev_time);
    assign load = (!alarm_valid || alarm_ack) && (pending != '0);

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            wr_hit[i]  = wr_en && (int'(wr_slot) == i);
`ifdef ALARM_SNOOZE_EN
            snz_hit[i] = alarm_valid && alarm_ack && snooze && (int'(alarm_slot) == i);
`else
            snz_hit[i] = 1'b0;
`endif
            // A same-cycle write to the slot suppresses its match entirely.
            match[i]   = tick && armed[i] && (slot_time[i] == cur_time) && !wr_hit[i];
        end
    end

    always_comb begin
        sel = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (pending[i]) sel = SLOT_W'(i);
    end

    // Matches land in pending one cycle after detection; disarm writes clear last.
    always_comb begin
        pend_nxt = pending;
        ov_set   = 1'b0;
        if (load) pend_nxt[sel] = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hit_q[i]) begin
                ov_set      = ov_set | pending[i];
                pend_nxt[i] = 1'b1;
            end
            if (wr_hit[i] && !wr_arm) pend_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (wr_hit[i] && wr_arm)
                slot_time[i] <= wr_time;
            else if (!wr_hit[i] && snz_hit[i])
                slot_time[i] <= cur_time + SNOOZE_DELAY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_time   <= '0;
            armed       <= '0;
            pending     <= '0;
            hit_q       <= '0;
            overrun     <= 1'b0;
            alarm_valid <= 1'b0;
            alarm_slot  <= '0;
        end else begin
            prev_time <= cur_time;
            hit_q     <= match;
            pending   <= pend_nxt;
            if (ov_set) overrun <= 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_hit[i])
                    armed[i] <= wr_arm;
                else if (snz_hit[i])
                    armed[i] <= 1'b1;
                else if (match[i])
                    armed[i] <= 1'b0;
            end
            if (load) begin
                alarm_valid <= 1'b1;
                alarm_slot  <= sel;
            end else if (alarm_valid && alarm_ack) begin
                alarm_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler: vector table plus reset and snooze sequences.
module tb_alarm_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cur_time;
    logic        wr_en;
    logic [1:0]  wr_slot;
    logic [15:0] wr_time;
    logic        wr_arm;
    logic        alarm_ack;
    logic        snooze;
    logic        alarm_valid;
    logic [1:0]  alarm_slot;
    logic [3:0]  armed;
    logic [3:0]  pending;
    logic        overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alarm_scheduler dut (
        .clk(clk), .rst(rst), .cur_time(cur_time),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_time(wr_time), .wr_arm(wr_arm),
        .alarm_ack(alarm_ack),
`ifdef ALARM_SNOOZE_EN
        .snooze(snooze),
`endif
        .alarm_valid(alarm_valid), .alarm_slot(alarm_slot),
        .armed(armed), .pending(pending), .overrun(overrun)
    );

    typedef struct {
        logic [15:0] cur;
        logic        we;
        logic [1:0]  ws;
        logic [15:0] wt;
        logic        wa;
        logic        ack;
        logic        ev;
        logic [1:0]  es;
        logic [3:0]  ea;
        logic [3:0]  ep;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [15:0] cur, input logic we, input logic [1:0] ws,
                       input logic [15:0] wt, input logic wa, input logic ack,
                       input logic ev, input logic [1:0] es, input logic [3:0] ea,
                       input logic [3:0] ep, input logic eo);
        vec_t v;
        v.cur = cur; v.we = we; v.ws = ws; v.wt = wt; v.wa = wa; v.ack = ack;
        v.ev = ev; v.es = es; v.ea = ea; v.ep = ep; v.eo = eo;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] cur, input logic we, input logic [1:0] ws,
                         input logic [15:0] wt, input logic wa, input logic ack);
        cur_time = cur; wr_en = we; wr_slot = ws; wr_time = wt; wr_arm = wa;
        alarm_ack = ack;
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(16'd0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
        snooze = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_valid", {15'd0, alarm_valid}, 16'd0);
        chk("rst_armed", {12'd0, armed}, 16'd0);
        chk("rst_pending", {12'd0, pending}, 16'd0);
        chk("rst_overrun", {15'd0, overrun}, 16'd0);
        edge1;
        rst = 1'b0;
        edge1;

        // single hit on slot1 at 100
        add(99, 1, 1, 100, 1, 0,  0, 0, 4'b0010, 4'b0000, 0);
        add(100, 0, 0, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(100, 0, 0, 0, 0, 0,   0, 0, 4'b0000, 4'b0010, 0);
        add(100, 0, 0, 0, 0, 0,   1, 1, 4'b0000, 4'b0000, 0);
        add(100, 0, 0, 0, 0, 1,   0, 0, 4'b0000, 4'b0000, 0);
        for (int k = 0; k < 45; k++)
            add(100, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
        // priority: slots 0,2,3 at 500 with ack held
        add(100, 1, 0, 500, 1, 0, 0, 0, 4'b0001, 4'b0000, 0);
        add(100, 1, 2, 500, 1, 0, 0, 0, 4'b0101, 4'b0000, 0);
        add(100, 1, 3, 500, 1, 0, 0, 0, 4'b1101, 4'b0000, 0);
        add(500, 0, 0, 0, 0, 1,   0, 0, 4'b0000, 4'b0000, 0);
        add(500, 0, 0, 0, 0, 1,   0, 0, 4'b0000, 4'b1101, 0);
        add(500, 0, 0, 0, 0, 1,   1, 0, 4'b0000, 4'b1100, 0);
        add(500, 0, 0, 0, 0, 1,   1, 2, 4'b0000, 4'b1000, 0);
        add(500, 0, 0, 0, 0, 1,   1, 3, 4'b0000, 4'b0000, 0);
        add(500, 0, 0, 0, 0, 1,   0, 0, 4'b0000, 4'b0000, 0);
        // collision: rewrite slot2 on the cycle time steps onto its old value
        add(500, 1, 2, 150, 1, 0, 0, 0, 4'b0100, 4'b0000, 0);
        add(150, 1, 2, 200, 1, 0, 0, 0, 4'b0100, 4'b0000, 0);
        add(150, 0, 0, 0, 0, 0,   0, 0, 4'b0100, 4'b0000, 0);
        add(150, 0, 0, 0, 0, 0,   0, 0, 4'b0100, 4'b0000, 0);
        add(200, 0, 0, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(200, 0, 0, 0, 0, 0,   0, 0, 4'b0000, 4'b0100, 0);
        add(200, 0, 0, 0, 0, 0,   1, 2, 4'b0000, 4'b0000, 0);
        add(200, 0, 0, 0, 0, 1,   0, 0, 4'b0000, 4'b0000, 0);
        // disarm before the time is reached
        add(200, 1, 1, 300, 1, 0, 0, 0, 4'b0010, 4'b0000, 0);
        add(200, 1, 1, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(300, 0, 0, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(300, 0, 0, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(300, 0, 0, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        // wrap and overrun, output held busy by slot3
        add(300, 1, 3, 65535, 1, 0, 0, 0, 4'b1000, 4'b0000, 0);
        add(300, 1, 0, 0, 1, 0,     0, 0, 4'b1001, 4'b0000, 0);
        add(65535, 0, 0, 0, 0, 0,   0, 0, 4'b0001, 4'b0000, 0);
        add(65535, 0, 0, 0, 0, 0,   0, 0, 4'b0001, 4'b1000, 0);
        add(65535, 0, 0, 0, 0, 0,   1, 3, 4'b0001, 4'b0000, 0);
        add(0, 0, 0, 0, 0, 0,       1, 3, 4'b0000, 4'b0000, 0);
        add(0, 0, 0, 0, 0, 0,       1, 3, 4'b0000, 4'b0001, 0);
        add(0, 1, 0, 1, 1, 0,       1, 3, 4'b0001, 4'b0001, 0);
        add(1, 0, 0, 0, 0, 0,       1, 3, 4'b0000, 4'b0001, 0);
        add(1, 0, 0, 0, 0, 0,       1, 3, 4'b0000, 4'b0001, 1);
        add(1, 0, 0, 0, 0, 1,       1, 0, 4'b0000, 4'b0000, 1);
        add(1, 0, 0, 0, 0, 1,       0, 0, 4'b0000, 4'b0000, 1);
        add(1, 0, 0, 0, 0, 0,       0, 0, 4'b0000, 4'b0000, 1);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].cur, vecs[k].we, vecs[k].ws, vecs[k].wt, vecs[k].wa, vecs[k].ack);
            edge1;
            chk($sformatf("v%0d_valid", k), {15'd0, alarm_valid}, {15'd0, vecs[k].ev});
            if (vecs[k].ev)
                chk($sformatf("v%0d_slot", k), {14'd0, alarm_slot}, {14'd0, vecs[k].es});
            chk($sformatf("v%0d_armed", k), {12'd0, armed}, {12'd0, vecs[k].ea});
            chk($sformatf("v%0d_pending", k), {12'd0, pending}, {12'd0, vecs[k].ep});
            chk($sformatf("v%0d_overrun", k), {15'd0, overrun}, {15'd0, vecs[k].eo});
        end

        // asynchronous reset while an event is presented
        drive(1, 1, 2, 9, 1, 0); edge1;
        drive(1, 1, 1, 5, 1, 0); edge1;
        drive(5, 0, 0, 0, 0, 0);
        edge1; edge1; edge1;
        chk("pre_rst_valid", {15'd0, alarm_valid}, 16'd1);
        chk("pre_rst_slot", {14'd0, alarm_slot}, 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {15'd0, alarm_valid}, 16'd0);
        chk("mid_rst_slot", {14'd0, alarm_slot}, 16'd0);
        chk("mid_rst_armed", {12'd0, armed}, 16'd0);
        chk("mid_rst_pending", {12'd0, pending}, 16'd0);
        chk("mid_rst_overrun", {15'd0, overrun}, 16'd0);
        drive(0, 0, 0, 0, 0, 0);
        edge1;
        rst = 1'b0;
        edge1;

`ifdef ALARM_SNOOZE_EN
        drive(0, 1, 1, 65400, 1, 0); edge1;
        drive(65400, 0, 0, 0, 0, 0);
        edge1; edge1; edge1;
        chk("snz_first_valid", {15'd0, alarm_valid}, 16'd1);
        chk("snz_first_slot", {14'd0, alarm_slot}, 16'd1);
        alarm_ack = 1'b1; snooze = 1'b1;
        edge1;
        alarm_ack = 1'b0; snooze = 1'b0;
        chk("snz_ack_valid", {15'd0, alarm_valid}, 16'd0);
        chk("snz_rearmed", {12'd0, armed}, 16'd2);
        cur_time = 163;
        edge1; edge1; edge1;
        chk("snz_early_valid", {15'd0, alarm_valid}, 16'd0);
        chk("snz_early_armed", {12'd0, armed}, 16'd2);
        cur_time = 164;
        edge1; edge1; edge1;
        chk("snz_hit_valid", {15'd0, alarm_valid}, 16'd1);
        chk("snz_hit_slot", {14'd0, alarm_slot}, 16'd1);
        chk("snz_hit_armed", {12'd0, armed}, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
